// File: rtl/spi_master_rx.sv
// SPI mode-0 receive-only master: frames one WORD_BITS-bit word per start
// request, sampling sdi MSB first on each rising sck edge.
module spi_master_rx #(
  parameter int unsigned CLK_DIV   = 5,
  parameter int unsigned WORD_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 sdi,
  output logic                 sck,
  output logic                 cs_n,
  output logic                 busy,
  output logic [WORD_BITS-1:0] sample_data,
  output logic                 sample_valid,
  output logic                 overrun
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = $clog2(WORD_BITS + 1);
  localparam logic [CNT_W-1:0] HC_TERM  = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     half_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [WORD_BITS-1:0] shreg;

  // Transfer sequencer: chip-select framing, sck generation, shifting and result hand-off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      half_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      sck          <= 1'b0;
      cs_n         <= 1'b1;
      busy         <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          sck <= 1'b0;
          if (start) begin
            state    <= SETUP;
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            half_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
          end
        end

        SETUP: begin
          if (start) overrun <= 1'b1;
          if (half_cnt == HC_TERM) begin
            half_cnt <= '0;
            state    <= SHIFT;
          end else begin
            half_cnt <= half_cnt + CNT_W'(1);
          end
        end

        SHIFT: begin
          if (start) overrun <= 1'b1;
          // The last falling edge has already happened once every rise is counted and sck is low.
          if (!sck && (bit_cnt == BIT_LAST)) begin
            state <= DONE;
          end else if (half_cnt == HC_TERM) begin
            half_cnt <= '0;
            sck      <= ~sck;
            if (!sck) begin
              shreg   <= {shreg[WORD_BITS-2:0], sdi};
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            half_cnt <= half_cnt + CNT_W'(1);
          end
        end

        DONE: begin
          if (start) overrun <= 1'b1;
          sample_data  <= shreg;
          sample_valid <= 1'b1;
          cs_n         <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end

        default: begin
          state <= IDLE;
          sck   <= 1'b0;
          cs_n  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_rx.sv
`timescale 1ns/1ps
// Bench for spi_master_rx: directed words from a mode-0 slave model, scoreboard-checked results.
module tb_spi_master_rx;
  localparam int unsigned CLK_DIV = 5;
  localparam int unsigned WB      = 16;
  localparam int unsigned LAT     = 167;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          sdi;
  logic          sck;
  logic          cs_n;
  logic          busy;
  logic [WB-1:0] sample_data;
  logic          sample_valid;
  logic          overrun;

  logic [WB-1:0] slave_word = '0;
  int unsigned   bitidx = 0;
  int unsigned   rise_cnt = 0;
  logic [WB-1:0] cap = '0;
  int unsigned   cyc = 0;

  int unsigned   n_checks = 0;
  int unsigned   n_pass = 0;

  typedef struct {
    logic [WB-1:0] word;
    int unsigned   edge_no;
  } exp_t;
  exp_t sbq[$];

  spi_master_rx #(.CLK_DIV(CLK_DIV), .WORD_BITS(WB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sdi(sdi),
    .sck(sck), .cs_n(cs_n), .busy(busy), .sample_data(sample_data),
    .sample_valid(sample_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: next bit presented after each sck fall, restarted whenever cs_n rises.
  always @(negedge sck or posedge cs_n) begin
    if (cs_n) bitidx <= 0;
    else      bitidx <= bitidx + 1;
  end

  always_comb begin
    sdi = 1'b0;
    if (!cs_n && bitidx < WB) sdi = slave_word[WB-1-bitidx];
  end

  // Observe what the master actually clocks: rising sck count and the bits seen on sdi.
  always @(posedge sck or negedge cs_n) begin
    if (!sck) begin
      rise_cnt <= 0;
      cap      <= '0;
    end else begin
      rise_cnt <= rise_cnt + 1;
      cap      <= {cap[WB-2:0], sdi};
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  // Monitor: every sample_valid pops one expected word and checks data, latency and framing.
  always @(posedge clk) begin
    #1;
    if (sample_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid", 32'(sample_valid), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sample_data", 32'(sample_data), 32'(e.word));
        check("latency", cyc - e.edge_no, LAT);
        check("sck_rises", rise_cnt, WB);
        check("bits_on_wire", 32'(cap), 32'(e.word));
        check("sck_low_at_valid", 32'(sck), 32'd0);
      end
    end
  end

  task automatic go(input logic [WB-1:0] w);
    @(negedge clk);
    slave_word = w;
    start = 1'b1;
    sbq.push_back('{w, cyc + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (sample_valid) seen = 1'b1;
    end
    check("valid_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    logic [WB-1:0] sweep [4];
    bit            reached;
    sweep[0] = 16'h5A5A; sweep[1] = 16'hFFFF; sweep[2] = 16'h0000; sweep[3] = 16'h1234;

    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_data", 32'(sample_data), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;

    // Idle: outputs quiet for 100 cycles with no start.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outputs", 32'({sck, cs_n, busy, sample_valid}), 32'b0100);
    end

    // Basic transfer, then a back-to-back pattern sweep.
    go(16'hA5A5);
    check("busy_during_xfer", 32'(busy), 32'd1);
    wait_valid();
    foreach (sweep[k]) begin
      @(negedge clk);
      check("cs_n_gap_high", 32'(cs_n), 32'd1);
      slave_word = sweep[k];
      start = 1'b1;
      sbq.push_back('{sweep[k], cyc + 1});
      @(posedge clk);
      #1;
      start = 1'b0;
      check("cs_n_low_next_edge", 32'(cs_n), 32'd0);
      wait_valid();
    end
    check("no_overrun_b2b", 32'(overrun), 32'd0);

    // Bit order: lone MSB and LSB.
    repeat (3) @(negedge clk);
    go(16'h8001);
    wait_valid();
    check("data_hold", 32'(sample_data), 32'h8001);

    // Overrun: second start 50 cycles into the transfer is dropped and sticks.
    repeat (3) @(negedge clk);
    go(16'h3C3C);
    repeat (48) @(negedge clk);
    check("overrun_before", 32'(overrun), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("overrun_set", 32'(overrun), 32'd1);
    wait_valid();
    repeat (20) @(negedge clk);
    check("overrun_sticky", 32'(overrun), 32'd1);
    check("data_after_overrun", 32'(sample_data), 32'h3C3C);

    // Reset mid-word after 8 rising sck edges of 0xBEEF.
    go(16'hBEEF);
    reached = 1'b0;
    for (int i = 0; i < 500 && !reached; i++) begin
      @(posedge clk);
      #1;
      if (rise_cnt >= 8) reached = 1'b1;
    end
    check("reached_8_rises", 32'(reached), 32'd1);
    #2;
    reset_n = 1'b0;
    sbq.delete();
    #1;
    check("midrst_sck", 32'(sck), 32'd0);
    check("midrst_cs_n", 32'(cs_n), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", 32'(sample_data), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk);

    // Release with start already high and held 3 cycles: one transfer, extra cycles flag overrun.
    reset_n = 1'b1;
    slave_word = 16'hCAFE;
    start = 1'b1;
    sbq.push_back('{16'hCAFE, cyc + 1});
    @(posedge clk);
    #1;
    check("first_edge_cs_n", 32'(cs_n), 32'd0);
    check("first_edge_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    check("held_start_overrun", 32'(overrun), 32'd1);
    wait_valid();
    repeat (CLK_DIV * 50) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);
    check("idle_after_all", 32'({sck, cs_n, busy}), 32'b010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
